lcd_spi_sink: RTL and testbench
===============================

# lcd_spi_sink

Receive end of the 4-wire LCD serial link (sda, scl, cs, rs) that our LCD driver emits. Deserializes bytes, decodes the ST7735 command subset the driver uses (SLPOUT, DISPON/OFF, CASET, RASET, RAMWR, optional MADCTL), and emits addressed RGB565 pixel writes. Sits in front of a framebuffer or VGA scan-out for on-board mirroring and simulation.

## Interface
- `WIDTH`, 128: panel columns.
- `HEIGHT`, 160: panel rows.
- `cin`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `sda`, `scl`, `cs`, `rs`  in  1 each  asynchronous link inputs.
- `pix_valid`  out  1  one-cycle pixel write strobe.
- `pix_x`  out  $clog2(WIDTH)  column of the write.
- `pix_y`  out  $clog2(HEIGHT)  row of the write.
- `pix_data`  out  16  RGB565 `{r[4:0],g[5:0],b[4:0]}`.
- `frame_start`  out  1  one-cycle pulse on each RAMWR command.
- `awake`  out  1  set by SLPOUT (0x11).
- `disp_on`  out  1  set by DISPON (0x29), cleared by DISPOFF (0x28).

## Operation
- Link: SPI mode 0, MSB first, 8-bit bytes; `sda` sampled on `scl` rising edge while `cs` low; `rs` sampled with bit 0 (0 = command, 1 = data).
- `cs` high discards any partial byte and resets bit count; command/parameter context persists across `cs` pulses.
- Command byte: clears parameter index, sets current command. Unlisted opcodes: their data bytes are ignored.
- CASET 0x2A / RASET 0x2B: 4 data bytes, start hi, start lo, end hi, end lo; committed on 4th byte; values clamped to WIDTH-1 / HEIGHT-1; if start > end after clamping, end := start. Bytes beyond the 4th ignored.
- RAMWR 0x2C: pulses `frame_start`, loads cursor (x := XS, y := YS). Data bytes pair hi then lo into one pixel; after each pixel x++; x past XE wraps to XS with y++; y past YE wraps to YS. Odd trailing byte is dropped at the next command.
- States: IDLE, PARAM (CASET/RASET), PIXEL_HI, PIXEL_LO, IGNORE. Any command byte returns to dispatch from every state.

## Timing
- Each `scl` high and low phase must last ≥ 2 `cin` cycles; `cs` setup to first `scl` rise ≥ 2 cycles.
- 2-flop synchronizers on all four inputs; `scl` rise detected on synchronized signal.
- `pix_valid`, `pix_x/y`, `pix_data`, `frame_start` registered; valid 4 `cin` cycles after raw `scl` rise of the final (bit 0) of the lo byte; strobes last exactly 1 cycle.
- Reset (low at a `cin` edge): outputs 0, window XS=0, XE=WIDTH-1, YS=0, YE=HEIGHT-1, state IDLE, cursor 0, partial byte dropped; mid-byte or mid-pixel reset loses that data.

## Configuration
- `LCD_SPI_SINK_MADCTL_EN` defined: MADCTL 0x36 accepted, 1 data byte; bit 7 MY mirrors y (HEIGHT-1-y), bit 6 MX mirrors x, bit 5 MV swaps row/column stepping (y advances first); applied to output coordinates; reset value 0x00.
- Undefined: 0x36 treated as an unlisted opcode, its data ignored; no mirroring logic.

## Structure
- Shared `lcd_pkg`: opcode constants (CMD_SLPOUT, CMD_DISPON, CMD_DISPOFF, CMD_CASET, CMD_RASET, CMD_RAMWR, CMD_MADCTL), default WIDTH/HEIGHT, `rgb565_t` typedef, state enum.
- One sub-module `spi_byte_rx`: synchronizers, edge detect, shift register; outputs `byte_valid`, `byte`, `byte_is_data`.

## Test plan
- Reset, then DISPON and SLPOUT command bytes -> `disp_on`=1, `awake`=1, no `pix_valid`.
- RAMWR then data 0xF8,0x00 -> `frame_start` pulse, then one `pix_valid` at x=0, y=0, data 0xF800.
- CASET 0,2,0,3; RASET 0,5,0,5; RAMWR; 3 pixels -> writes at (2,5),(3,5),(2,5): column wrap and row wrap.
- CASET end 0x00,0xFF -> XE clamps to 127; 129 pixels from x=0 wrap to x=0, y+1 on the 129th.
- `cs` deasserted after 5 bits of a data byte, then full byte 0x12,0x34 -> only pixel 0x1234 emitted.
- With `LCD_SPI_SINK_MADCTL_EN`: MADCTL 0xC0, window full, RAMWR, 1 pixel -> write at x=127, y=159.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared opcodes, geometry defaults, pixel type and decoder states
//
// Purpose: common definitions for the LCD serial-link sink and its byte receiver.
// Ports: none (package).
// Optional feature macro: LCD_SPI_SINK_MADCTL_EN (consumed by lcd_spi_sink).

package lcd_pkg;

  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;

  localparam int LCD_WIDTH  = 128;
  localparam int LCD_HEIGHT = 160;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARAM,
    ST_PIXEL_HI,
    ST_PIXEL_LO,
    ST_IGNORE
  } lcd_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - synchronizes the raw link and deserializes SPI mode-0 bytes
//
// Purpose: 2-flop synchronizers on sda/scl/cs/rs, scl rising-edge detect on the
// synchronized clock, MSB-first shift register with a bit counter cleared while cs
// is high.
// Ports:
//   clk_i           system clock
//   resetn_i        synchronous active-low reset
//   sda_i, scl_i,   asynchronous link inputs
//   cs_i, rs_i
//   byte_valid_o    one-cycle strobe, a complete byte is on byte_o
//   byte_o          received byte
//   byte_is_data_o  rs sampled with bit 0 (1 = data, 0 = command)

module spi_byte_rx
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       sda_i,
  input  logic       scl_i,
  input  logic       cs_i,
  input  logic       rs_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_is_data_o
);

  // scl_q[2] is the previous synchronized value used for edge detection
  logic [2:0] scl_q;
  logic [1:0] sda_q;
  logic [1:0] cs_q;
  logic [1:0] rs_q;
  logic [6:0] shift_q;
  logic [2:0] cnt_q;
  logic       byte_valid_q;
  logic [7:0] byte_q;
  logic       is_data_q;
  logic       scl_rise;

  assign scl_rise = scl_q[1] & ~scl_q[2];

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      scl_q        <= '0;
      sda_q        <= '0;
      cs_q         <= 2'b11;
      rs_q         <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      is_data_q    <= 1'b0;
    end else begin
      scl_q        <= {scl_q[1:0], scl_i};
      sda_q        <= {sda_q[0], sda_i};
      cs_q         <= {cs_q[0], cs_i};
      rs_q         <= {rs_q[0], rs_i};
      byte_valid_q <= 1'b0;
      if (cs_q[1]) begin
        // deselect drops any partial byte
        cnt_q <= '0;
      end else if (scl_rise) begin
        shift_q <= {shift_q[5:0], sda_q[1]};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_q       <= {shift_q, sda_q[1]};
          is_data_q    <= rs_q[1];
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  assign byte_valid_o   = byte_valid_q;
  assign byte_o         = byte_q;
  assign byte_is_data_o = is_data_q;

endmodule

// File: rtl/lcd_spi_sink.sv
// rtl/lcd_spi_sink.sv - ST7735-subset command decoder emitting addressed RGB565 writes
//
// Purpose: decodes SLPOUT, DISPON/DISPOFF, CASET, RASET, RAMWR (and MADCTL when
// LCD_SPI_SINK_MADCTL_EN is defined) from the serial link and produces one pixel
// write strobe per hi/lo data byte pair inside the current address window.
// Ports:
//   cin          system clock
//   reset        synchronous active-low reset
//   sda, scl,    asynchronous link inputs
//   cs, rs
//   pix_valid    one-cycle pixel write strobe
//   pix_x/pix_y  write coordinates
//   pix_data     RGB565 pixel
//   frame_start  one-cycle pulse per RAMWR
//   awake        set by SLPOUT
//   disp_on      set by DISPON, cleared by DISPOFF
// Macro: LCD_SPI_SINK_MADCTL_EN enables MADCTL mirroring / row-column swap.

module lcd_spi_sink
  import lcd_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT
) (
  input  logic                      cin,
  input  logic                      reset,
  input  logic                      sda,
  input  logic                      scl,
  input  logic                      cs,
  input  logic                      rs,
  output logic                      pix_valid,
  output logic [$clog2(WIDTH)-1:0]  pix_x,
  output logic [$clog2(HEIGHT)-1:0] pix_y,
  output logic [15:0]               pix_data,
  output logic                      frame_start,
  output logic                      awake,
  output logic                      disp_on
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [15:0]   XLIM16 = 16'(WIDTH - 1);
  localparam logic [15:0]   YLIM16 = 16'(HEIGHT - 1);
  localparam logic [XW-1:0] XMAX   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX   = YW'(HEIGHT - 1);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_is_data;

  spi_byte_rx u_rx (
    .clk_i          (cin),
    .resetn_i       (reset),
    .sda_i          (sda),
    .scl_i          (scl),
    .cs_i           (cs),
    .rs_i           (rs),
    .byte_valid_o   (rx_valid),
    .byte_o         (rx_byte),
    .byte_is_data_o (rx_is_data)
  );

  lcd_state_e    state_q;
  logic [7:0]    cmd_q;
  logic [2:0]    pidx_q;
  logic [7:0]    p0_q, p1_q, p2_q;
  logic [7:0]    hi_q;
  logic [XW-1:0] xs_q, xe_q, cur_x_q;
  logic [YW-1:0] ys_q, ye_q, cur_y_q;
  logic          pix_valid_q;
  logic [XW-1:0] pix_x_q;
  logic [YW-1:0] pix_y_q;
  rgb565_t       pix_data_q;
  logic          frame_start_q;
  logic          awake_q;
  logic          disp_on_q;

  // Window commit values, computed as the 4th parameter byte arrives
  logic [15:0]   s16, e16;
  logic [XW-1:0] cx_s_d, cx_e0_d, cx_e_d;
  logic [YW-1:0] cy_s_d, cy_e0_d, cy_e_d;

  assign s16 = {p0_q, p1_q};
  assign e16 = {p2_q, rx_byte};

  always_comb begin
    cx_s_d  = (s16 > XLIM16) ? XMAX : s16[XW-1:0];
    cx_e0_d = (e16 > XLIM16) ? XMAX : e16[XW-1:0];
    cx_e_d  = (cx_s_d > cx_e0_d) ? cx_s_d : cx_e0_d;
    cy_s_d  = (s16 > YLIM16) ? YMAX : s16[YW-1:0];
    cy_e0_d = (e16 > YLIM16) ? YMAX : e16[YW-1:0];
    cy_e_d  = (cy_s_d > cy_e0_d) ? cy_s_d : cy_e0_d;
  end

  // Cursor stepping and output coordinate mapping
  logic [XW-1:0] nx_d, ox_d;
  logic [YW-1:0] ny_d, oy_d;
  logic          x_end, y_end;

  assign x_end = (cur_x_q >= xe_q);
  assign y_end = (cur_y_q >= ye_q);

`ifdef LCD_SPI_SINK_MADCTL_EN
  // mad_q = {MY, MX, MV}
  logic [2:0] mad_q;

  always_comb begin
    nx_d = cur_x_q;
    ny_d = cur_y_q;
    if (mad_q[0]) begin
      if (y_end) begin
        ny_d = ys_q;
        nx_d = x_end ? xs_q : cur_x_q + 1'b1;
      end else begin
        ny_d = cur_y_q + 1'b1;
      end
    end else begin
      if (x_end) begin
        nx_d = xs_q;
        ny_d = y_end ? ys_q : cur_y_q + 1'b1;
      end else begin
        nx_d = cur_x_q + 1'b1;
      end
    end
  end

  assign ox_d = mad_q[1] ? XMAX - cur_x_q : cur_x_q;
  assign oy_d = mad_q[2] ? YMAX - cur_y_q : cur_y_q;
`else
  always_comb begin
    nx_d = cur_x_q;
    ny_d = cur_y_q;
    if (x_end) begin
      nx_d = xs_q;
      ny_d = y_end ? ys_q : cur_y_q + 1'b1;
    end else begin
      nx_d = cur_x_q + 1'b1;
    end
  end

  assign ox_d = cur_x_q;
  assign oy_d = cur_y_q;
`endif

  always_ff @(posedge cin) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      pidx_q        <= '0;
      p0_q          <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      hi_q          <= '0;
      xs_q          <= '0;
      xe_q          <= XMAX;
      ys_q          <= '0;
      ye_q          <= YMAX;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
      awake_q       <= 1'b0;
      disp_on_q     <= 1'b0;
`ifdef LCD_SPI_SINK_MADCTL_EN
      mad_q         <= '0;
`endif
    end else begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      if (rx_valid && !rx_is_data) begin
        // every command byte re-dispatches, dropping any half pixel or partial params
        cmd_q  <= rx_byte;
        pidx_q <= '0;
        case (rx_byte)
          CMD_SLPOUT: begin
            awake_q <= 1'b1;
            state_q <= ST_IDLE;
          end
          CMD_DISPON: begin
            disp_on_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
          CMD_DISPOFF: begin
            disp_on_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
          CMD_CASET, CMD_RASET: state_q <= ST_PARAM;
          CMD_RAMWR: begin
            frame_start_q <= 1'b1;
            cur_x_q       <= xs_q;
            cur_y_q       <= ys_q;
            state_q       <= ST_PIXEL_HI;
          end
`ifdef LCD_SPI_SINK_MADCTL_EN
          CMD_MADCTL: state_q <= ST_PARAM;
`endif
          default: state_q <= ST_IGNORE;
        endcase
      end else if (rx_valid) begin
        case (state_q)
          ST_PARAM: begin
            // saturate so bytes past the 4th are ignored
            if (pidx_q != 3'd4) pidx_q <= pidx_q + 3'd1;
`ifdef LCD_SPI_SINK_MADCTL_EN
            if (cmd_q == CMD_MADCTL) begin
              if (pidx_q == 3'd0) mad_q <= rx_byte[7:5];
            end else
`endif
            begin
              case (pidx_q)
                3'd0: p0_q <= rx_byte;
                3'd1: p1_q <= rx_byte;
                3'd2: p2_q <= rx_byte;
                3'd3: begin
                  if (cmd_q == CMD_CASET) begin
                    xs_q <= cx_s_d;
                    xe_q <= cx_e_d;
                  end else begin
                    ys_q <= cy_s_d;
                    ye_q <= cy_e_d;
                  end
                end
                default: ;
              endcase
            end
          end
          ST_PIXEL_HI: begin
            hi_q    <= rx_byte;
            state_q <= ST_PIXEL_LO;
          end
          ST_PIXEL_LO: begin
            pix_valid_q <= 1'b1;
            pix_x_q     <= ox_d;
            pix_y_q     <= oy_d;
            pix_data_q  <= {hi_q, rx_byte};
            cur_x_q     <= nx_d;
            cur_y_q     <= ny_d;
            state_q     <= ST_PIXEL_HI;
          end
          default: ;
        endcase
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign awake       = awake_q;
  assign disp_on     = disp_on_q;

endmodule

// File: tb/tb_lcd_spi_sink.sv
// tb/tb_lcd_spi_sink.sv - randomized self-checking bench for lcd_spi_sink

module tb_lcd_spi_sink;

  localparam int W = 128;
  localparam int H = 160;

  logic        cin   = 1'b0;
  logic        reset = 1'b0;
  logic        sda   = 1'b0;
  logic        scl   = 1'b0;
  logic        cs    = 1'b1;
  logic        rs    = 1'b0;
  logic        pix_valid;
  logic [6:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_start;
  logic        awake;
  logic        disp_on;

  lcd_spi_sink #(.WIDTH(W), .HEIGHT(H)) dut (
    .cin         (cin),
    .reset       (reset),
    .sda         (sda),
    .scl         (scl),
    .cs          (cs),
    .rs          (rs),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .awake       (awake),
    .disp_on     (disp_on)
  );

  always #5 cin = ~cin;

  int cyc = 0;
  always @(posedge cin) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; int d; } pix_t;
  pix_t exp_q[$];

  int m_cmd, m_cnt, m_xs, m_xe, m_ys, m_ye, m_cx, m_cy, m_hi, m_mad, m_fs, m_pix;
  bit m_hi_ok, m_awake, m_disp;
  int m_par[4];

  task automatic model_reset();
    m_cmd = 0; m_cnt = 0; m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1;
    m_cx = 0; m_cy = 0; m_hi = 0; m_hi_ok = 0; m_awake = 0; m_disp = 0; m_mad = 0;
  endtask

  // Pixels are walked as a linear index over the window; MV makes columns the major axis.
  task automatic model_advance();
    int w, h, idx;
    w = m_xe - m_xs + 1;
    h = m_ye - m_ys + 1;
    if ((m_mad & 'h20) != 0) begin
      idx = ((m_cx - m_xs) * h + (m_cy - m_ys) + 1) % (w * h);
      m_cx = m_xs + idx / h;
      m_cy = m_ys + idx % h;
    end else begin
      idx = ((m_cy - m_ys) * w + (m_cx - m_xs) + 1) % (w * h);
      m_cx = m_xs + idx % w;
      m_cy = m_ys + idx / w;
    end
  endtask

  task automatic model_byte(input int b, input bit d);
    int s, e, lim;
    pix_t p;
    if (!d) begin
      m_cmd = b; m_cnt = 0; m_hi_ok = 0;
      case (b)
        'h11: m_awake = 1;
        'h29: m_disp = 1;
        'h28: m_disp = 0;
        'h2C: begin m_cx = m_xs; m_cy = m_ys; m_fs++; end
        default: ;
      endcase
    end else begin
      case (m_cmd)
        'h2A, 'h2B: begin
          if (m_cnt < 4) m_par[m_cnt] = b;
          if (m_cnt == 3) begin
            lim = (m_cmd == 'h2A) ? W - 1 : H - 1;
            s = m_par[0] * 256 + m_par[1];
            e = m_par[2] * 256 + m_par[3];
            if (s > lim) s = lim;
            if (e > lim) e = lim;
            if (s > e) e = s;
            if (m_cmd == 'h2A) begin m_xs = s; m_xe = e; end
            else begin m_ys = s; m_ye = e; end
          end
          m_cnt++;
        end
        'h2C: begin
          if (!m_hi_ok) begin
            m_hi = b; m_hi_ok = 1;
          end else begin
            p.x = ((m_mad & 'h40) != 0) ? W - 1 - m_cx : m_cx;
            p.y = ((m_mad & 'h80) != 0) ? H - 1 - m_cy : m_cy;
            p.d = m_hi * 256 + b;
            exp_q.push_back(p);
            m_pix++;
            model_advance();
            m_hi_ok = 0;
          end
        end
`ifdef LCD_SPI_SINK_MADCTL_EN
        'h36: begin
          if (m_cnt == 0) m_mad = b;
          m_cnt++;
        end
`endif
        default: ;
      endcase
    end
  endtask

  // ---------------- monitor ----------------
  bit mon_en = 0;
  int pix_seen = 0, fs_seen = 0, last_rise = 0;
  int last_x = -1, last_y = -1, last_d = -1;

  always @(negedge cin) begin
    pix_t e;
    if (mon_en) begin
      if (pix_valid) begin
        pix_seen++;
        last_x = int'(pix_x); last_y = int'(pix_y); last_d = int'(pix_data);
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix_x", pix_x, e.x);
          check("pix_y", pix_y, e.y);
          check("pix_data", pix_data, e.d);
          check("pix_latency", cyc - last_rise, 4);
        end
      end
      if (frame_start) fs_seen++;
    end
  end

  // ---------------- link drivers ----------------
  task automatic spi_bits(input logic [7:0] b, input logic d, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) begin
      @(posedge cin); #1;
      sda = b[i]; rs = d;
      repeat (3) @(posedge cin);
      #1; scl = 1'b1; last_rise = cyc;
      repeat (3) @(posedge cin);
      #1; scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    model_byte(int'(b), d);
    if (cs) begin
      @(posedge cin); #1; cs = 1'b0;
      repeat (3) @(posedge cin);
    end
    spi_bits(b, d, 8);
  endtask

  task automatic cs_idle();
    @(posedge cin); #1; cs = 1'b1;
    repeat (4) @(posedge cin);
  endtask

  task automatic do_reset();
    @(posedge cin); #1;
    reset = 1'b0; cs = 1'b1; scl = 1'b0;
    repeat (3) @(posedge cin);
    #1; reset = 1'b1;
    model_reset();
  endtask

  task automatic settle();
    repeat (8) @(posedge cin);
    @(negedge cin);
  endtask

  task automatic send_win(input logic [7:0] c, input int s, input int e);
    send_byte(c, 0);
    send_byte(8'(s >> 8), 1); send_byte(8'(s), 1);
    send_byte(8'(e >> 8), 1); send_byte(8'(e), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, n, base;
    logic [7:0] b;
    m_fs = 0; m_pix = 0;
    model_reset();
    repeat (3) @(posedge cin);
    @(negedge cin);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_awake", awake, 0);
    check("rst_disp_on", disp_on, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_data", pix_data, 0);
    #1; reset = 1'b1;
    mon_en = 1;

    send_byte(8'h29, 0);
    send_byte(8'h11, 0);
    settle();
    check("dispon", disp_on, 1);
    check("slpout", awake, 1);
    check("no_pix_after_cmds", pix_seen, 0);

    send_byte(8'h2C, 0);
    send_byte(8'hF8, 1);
    send_byte(8'h00, 1);
    settle();
    check("first_fs", fs_seen, 1);
    check("first_count", pix_seen, 1);
    check("first_x", last_x, 0);
    check("first_y", last_y, 0);
    check("first_data", last_d, 'hF800);

    send_win(8'h2A, 2, 3);
    send_win(8'h2B, 5, 5);
    send_byte(8'h2C, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);
    settle();
    check("wrap_count", pix_seen, 4);
    check("wrap_x", last_x, 2);
    check("wrap_y", last_y, 5);

    send_win(8'h2A, 0, 'hFF);
    send_win(8'h2B, 0, 'h9F);
    send_byte(8'h2C, 0);
    for (int i = 0; i < 258; i++) send_byte(8'($urandom), 1);
    settle();
    check("clamp_count", pix_seen, 133);
    check("clamp_x", last_x, 0);
    check("clamp_y", last_y, 1);

    send_byte(8'h2C, 0);
    spi_bits(8'hAB, 1, 5);
    cs_idle();
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    settle();
    check("csabort_count", pix_seen, 134);
    check("csabort_data", last_d, 'h1234);

    send_byte(8'h28, 0);
    settle();
    check("dispoff", disp_on, 0);

`ifdef LCD_SPI_SINK_MADCTL_EN
    send_byte(8'h36, 0); send_byte(8'hC0, 1);
    send_byte(8'h2C, 0);
    send_byte(8'h5A, 1); send_byte(8'hA5, 1);
    settle();
    check("madctl_x", last_x, 127);
    check("madctl_y", last_y, 159);
    send_byte(8'h36, 0); send_byte(8'h00, 1);
`endif

    // reset in the middle of a pixel loses the half pixel and all context
    send_byte(8'h11, 0);
    send_byte(8'h2C, 0);
    send_byte(8'h55, 1);
    settle();
    check("pre_reset_queue", exp_q.size(), 0);
    do_reset();
    settle();
    check("midrst_awake", awake, 0);
    check("midrst_disp", disp_on, 0);
    base = pix_seen;
    send_byte(8'h66, 1);
    send_byte(8'h77, 1);
    settle();
    check("midrst_no_pix", pix_seen, base);

    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          send_byte(op == 0 ? 8'h2A : 8'h2B, 0);
          for (int k = 0; k < 4; k++) begin
            b = (k % 2 == 0) ? (($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00) : 8'($urandom);
            send_byte(b, 1);
          end
        end
        2: begin
          send_byte(8'h2C, 0);
          n = $urandom_range(0, 6);
          for (int k = 0; k < 2 * n; k++) send_byte(8'($urandom), 1);
          if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1);
        end
        3: begin
          b = ($urandom_range(0, 1) == 0) ? 8'h3A : 8'h36;
          send_byte(b, 0);
          send_byte(8'($urandom), 1);
          send_byte(8'($urandom), 1);
        end
        4: begin
          cs_idle();
          case ($urandom_range(0, 2))
            0: send_byte(8'h11, 0);
            1: send_byte(8'h29, 0);
            default: send_byte(8'h28, 0);
          endcase
        end
        default: begin
          send_byte(8'h2A, 0);
          send_byte(8'($urandom), 1);
          send_byte(8'($urandom), 1);
        end
      endcase
    end

    send_byte(8'h2C, 0);
    send_byte(8'hBE, 1);
    send_byte(8'hEF, 1);
    settle();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_pix_count", pix_seen, m_pix);
    check("final_fs_count", fs_seen, m_fs);
    check("final_awake", awake, m_awake);
    check("final_disp", disp_on, m_disp);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
